// File: rtl/pixel_stream_pkg.sv
// Shared types and constants for the pixel stream FIFO and its framing checker.
// Pure declarations, no logic or latency.
// Holds the default widths and the frame length for a 640x480 frame.
package pixel_stream_pkg;

  // 3 colour channels x (8 colour bits + 2 zero pad bits)
  localparam int DATA_W     = 30;
  // Beats per frame, 640 x 480
  localparam int NUM_PIXELS = 307200;
  // Wide enough to count every beat of a full frame
  localparam int PIX_CNT_W  = 19;

  // One stored beat: pixel word plus its framing markers
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } pixel_beat_t;

endpackage

// File: rtl/stream_frame_checker.sv
// Framing checker: verifies SOP/EOP positions of accepted beats against the frame length.
// Results register one cycle after the accepting edge.
// Passive observer of the input handshake; never stalls the stream.
module stream_frame_checker #(
  parameter int NUM_PIXELS = pixel_stream_pkg::NUM_PIXELS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        beat_accept,
  input  logic        beat_sop,
  input  logic        beat_eop,
  output logic [15:0] frame_count,
  output logic        frame_err
);
  import pixel_stream_pkg::*;

  localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(NUM_PIXELS - 1);

  // Index of the next expected beat within the current frame
  logic [PIX_CNT_W-1:0] pix_cnt;
  logic                 beat_bad;

  // A beat is bad when its markers disagree with where we think we are in the frame
  always_comb begin
    beat_bad = (beat_sop != (pix_cnt == '0)) || (beat_eop != (pix_cnt == LAST_PIX));
  end

  // Track frame position; on a bad beat, realign so an SOP beat starts a fresh frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt     <= '0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else if (beat_accept) begin
      if (beat_bad) begin
        frame_err <= 1'b1;
        pix_cnt   <= beat_sop ? PIX_CNT_W'(1) : '0;
      end else if (pix_cnt == LAST_PIX) begin
        pix_cnt <= '0;
      end else begin
        pix_cnt <= pix_cnt + 1'b1;
      end
      // Every accepted EOP counts as a frame, even a malformed one
      if (beat_eop) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_stream_fifo.sv
// First-word-fall-through pixel FIFO between a pixel source and a VGA sink, with input framing check.
// Latency: a beat pushed into an empty FIFO is visible at the output the cycle after the push edge.
// Backpressure: in_ready drops when full or in reset; a full FIFO still pops, blocking the push that cycle.
module pixel_stream_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_W     = pixel_stream_pkg::DATA_W,
  parameter int NUM_PIXELS = pixel_stream_pkg::NUM_PIXELS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_startofpacket,
  input  logic                       in_endofpacket,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_startofpacket,
  output logic                       out_endofpacket,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [15:0]                frame_count,
  output logic                       frame_err
);
  import pixel_stream_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  pixel_beat_t             mem [DEPTH];
  pixel_beat_t             wr_beat;
  pixel_beat_t             head;
  logic        [PTR_W-1:0] wr_ptr;
  logic        [PTR_W-1:0] rd_ptr;
  logic        [LVL_W-1:0] level_q;
  logic                    push;
  logic                    pop;

  // Handshake qualifiers and head-of-queue view straight from storage
  always_comb begin
    in_ready          = !reset && (level_q != FULL_LVL);
    out_valid         = (level_q != '0);
    push              = in_valid && in_ready;
    pop               = out_valid && out_ready;
    wr_beat.data      = in_data;
    wr_beat.sop       = in_startofpacket;
    wr_beat.eop       = in_endofpacket;
    head              = mem[rd_ptr];
    out_data          = head.data;
    out_startofpacket = head.sop;
    out_endofpacket   = head.eop;
    level             = level_q;
  end

  // Storage is not reset; contents are meaningless while out_valid is low
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_beat;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level moves by at most one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  stream_frame_checker #(
    .NUM_PIXELS (NUM_PIXELS)
  ) u_checker (
    .clk         (clk),
    .reset       (reset),
    .beat_accept (push),
    .beat_sop    (in_startofpacket),
    .beat_eop    (in_endofpacket),
    .frame_count (frame_count),
    .frame_err   (frame_err)
  );

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Testbench for pixel_stream_fifo: queue-based reference model with framing model.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// Frame length is overridden to 8 beats so framing scenarios stay short.
module tb_pixel_stream_fifo;
  import pixel_stream_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = 30;
  localparam int NP    = 8;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic [DW-1:0]    in_data;
  logic             in_startofpacket;
  logic             in_endofpacket;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    out_data;
  logic             out_startofpacket;
  logic             out_endofpacket;
  logic             out_valid;
  logic             out_ready;
  logic [LVL_W-1:0] level;
  logic [15:0]      frame_count;
  logic             frame_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  pixel_beat_t mq[$];
  int          m_pos = 0;
  logic [15:0] m_fc  = 0;
  logic        m_err = 0;

  pixel_stream_fifo #(
    .DEPTH      (DEPTH),
    .DATA_W     (DW),
    .NUM_PIXELS (NP)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .level             (level),
    .frame_count       (frame_count),
    .frame_err         (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame rule: beat k of a frame carries SOP iff k==0 and EOP iff k==NP-1
  function automatic void frame_model(input logic s, input logic e);
    if (s != (m_pos == 0) || e != (m_pos == NP - 1)) begin
      m_err = 1'b1;
      m_pos = s ? 1 : 0;
    end else begin
      m_pos = (m_pos + 1) % NP;
    end
    if (e) m_fc = m_fc + 16'd1;
  endfunction

  // One clock cycle: drive inputs, advance model at the edge, return at the falling edge
  task automatic tick(input logic v, input logic s, input logic e, input logic [DW-1:0] d, input logic r);
    bit push, pop;
    pixel_beat_t b;
    in_valid = v; in_startofpacket = s; in_endofpacket = e; in_data = d; out_ready = r;
    push = v && !reset && (mq.size() < DEPTH);
    pop  = r && (mq.size() > 0);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (push) begin
      b.data = d; b.sop = s; b.eop = e;
      mq.push_back(b);
      frame_model(s, e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 0; in_startofpacket = 0; in_endofpacket = 0; in_data = '0; out_ready = 0;
    reset = 1'b1;
    mq.delete(); m_pos = 0; m_fc = 0; m_err = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 0; in_startofpacket = 0; in_endofpacket = 0; in_data = '0; out_ready = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL reset_frame_count got=%0d exp=0", frame_count); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%0b exp=0", frame_err); end
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%0b exp=1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_latency();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_empty_valid got=%0b exp=0", out_valid); end
    tick(1, 1, 0, 30'h3FF00000, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%0b exp=1", out_valid); end
    total++; if (out_data !== 30'h3FF00000) begin bad++; $display("FAIL lat_data got=%0h exp=3ff00000", out_data); end
    total++; if (level !== LVL_W'(1)) begin bad++; $display("FAIL lat_level1 got=%0d exp=1", level); end
    tick(0, 0, 0, '0, 1);
    total++; if (level !== '0) begin bad++; $display("FAIL lat_level0 got=%0d exp=0", level); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_drained_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      tick(1, 0, 0, DW'($urandom), 0);
      total++; if (level !== LVL_W'(mq.size())) begin bad++; $display("FAIL fill_level got=%0d exp=%0d", level, mq.size()); end
    end
    total++; if (level !== LVL_W'(DEPTH)) begin bad++; $display("FAIL fill_full_level got=%0d exp=%0d", level, DEPTH); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_full_in_ready got=%0b exp=0", in_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (out_valid !== 1'b1 || {out_data, out_startofpacket, out_endofpacket} !== mq[0]) begin
        bad++; $display("FAIL drain_head got=%0b/%0h exp=1/%0h", out_valid, {out_data, out_startofpacket, out_endofpacket}, mq[0]);
      end
      tick(0, 0, 0, '0, 1);
    end
    total++; if (level !== '0 || out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0d/%0b exp=0/0", level, out_valid); end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 0; i < DEPTH; i++) tick(1, 0, 0, DW'($urandom), 0);
    for (int i = 0; i < 20; i++) begin
      total++;
      if (out_valid !== 1'b1 || {out_data, out_startofpacket, out_endofpacket} !== mq[0]) begin
        bad++; $display("FAIL full_head got=%0b/%0h exp=1/%0h", out_valid, {out_data, out_startofpacket, out_endofpacket}, mq[0]);
      end
      tick(1, 0, 0, DW'($urandom), 1);
      total++; if (level !== LVL_W'(mq.size())) begin bad++; $display("FAIL full_level got=%0d exp=%0d", level, mq.size()); end
      total++; if (in_ready !== (mq.size() < DEPTH)) begin bad++; $display("FAIL full_in_ready got=%0b exp=%0b", in_ready, mq.size() < DEPTH); end
    end
    while (mq.size() > 0) begin
      total++;
      if ({out_data, out_startofpacket, out_endofpacket} !== mq[0]) begin
        bad++; $display("FAIL full_drain got=%0h exp=%0h", {out_data, out_startofpacket, out_endofpacket}, mq[0]);
      end
      tick(0, 0, 0, '0, 1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 6) == 0, DW'($urandom), ($urandom % 3) != 0);
      total++; if (level !== LVL_W'(mq.size())) begin bad++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", i, level, mq.size()); end
      total++; if (in_ready !== (mq.size() < DEPTH)) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%0b", i, in_ready); end
      total++; if (out_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rnd_out_valid cyc=%0d got=%0b", i, out_valid); end
      if (mq.size() > 0) begin
        total++;
        if ({out_data, out_startofpacket, out_endofpacket} !== mq[0]) begin
          bad++; $display("FAIL rnd_head cyc=%0d got=%0h exp=%0h", i, {out_data, out_startofpacket, out_endofpacket}, mq[0]);
        end
      end
      total++; if (frame_count !== m_fc) begin bad++; $display("FAIL rnd_frame_count cyc=%0d got=%0d exp=%0d", i, frame_count, m_fc); end
      total++; if (frame_err !== m_err) begin bad++; $display("FAIL rnd_frame_err cyc=%0d got=%0b exp=%0b", i, frame_err, m_err); end
    end
  endtask

  task automatic test_frames();
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NP; i++) tick(1, i == 0, i == NP - 1, DW'($urandom), $urandom % 2);
    end
    total++; if (frame_count !== 16'd2) begin bad++; $display("FAIL frames_count got=%0d exp=2", frame_count); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL frames_err got=%0b exp=0", frame_err); end
  endtask

  task automatic test_frame_err();
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, i == 0, 0, DW'($urandom), 1);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_before got=%0b exp=0", frame_err); end
    tick(1, 0, 1, DW'($urandom), 1);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_set got=%0b exp=1", frame_err); end
    total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", frame_count); end
    for (int i = 0; i < NP; i++) tick(1, i == 0, i == NP - 1, DW'($urandom), 1);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_sticky got=%0b exp=1", frame_err); end
    total++; if (frame_count !== 16'd2) begin bad++; $display("FAIL ferr_count2 got=%0d exp=2", frame_count); end
    total++; if (frame_err !== m_err) begin bad++; $display("FAIL ferr_model got=%0b exp=%0b", frame_err, m_err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 7; i++) tick(1, i == 0, 0, DW'($urandom), 0);
    total++; if (level !== LVL_W'(7)) begin bad++; $display("FAIL ares_level7 got=%0d exp=7", level); end
    #2 reset = 1'b1;
    #1;
    total++; if (level !== '0) begin bad++; $display("FAIL ares_level got=%0d exp=0", level); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ares_out_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ares_in_ready got=%0b exp=0", in_ready); end
    mq.delete(); m_pos = 0; m_fc = 0; m_err = 0;
    @(negedge clk);
    reset = 1'b0;
    tick(1, 1, 0, 30'h155, 0);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ares_sop_err got=%0b exp=0", frame_err); end
    total++; if (level !== LVL_W'(1) || out_data !== 30'h155) begin bad++; $display("FAIL ares_push got=%0d/%0h exp=1/155", level, out_data); end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 0; in_startofpacket = 0; in_endofpacket = 0; in_data = '0; out_ready = 0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_fill_drain();
    test_full_simul();
    test_frames();
    test_frame_err();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
